// File: rtl/fir_engine_ctrl.sv
// Sequencer for the 11-tap FIR: run control, circular-buffer MAC over two bram11 RAMs and tap-RAM arbitration.
// Optional macro FIR_TLAST_CHECK_EN enables the sticky ss_tlast framing check on err.
//
// state   | meaning
// IDLE    | no run since reset, cfg path owns the tap RAM
// CLEAR   | zeroing the data history, one word per cycle
// WAIT_IN | waiting for the next input sample
// MAC     | 11 read issues plus one drain cycle for the RAM latency
// OUT     | presenting the result until the sink accepts it
// DONE    | run complete, cfg path owns the tap RAM
module fir_engine_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic                   err,
    input  logic                   cfg_req,
    input  logic                   cfg_we,
    input  logic [pADDR_WIDTH-1:0] cfg_addr,
    input  logic [pDATA_WIDTH-1:0] cfg_wdata,
    output logic                   cfg_gnt,
    output logic                   cfg_rvalid,
    output logic [pDATA_WIDTH-1:0] cfg_rdata,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic                   sm_tlast,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic [3:0]             data_WE,
    output logic                   data_EN,
    output logic [pDATA_WIDTH-1:0] data_Di,
    output logic [pADDR_WIDTH-1:0] data_A,
    input  logic [pDATA_WIDTH-1:0] data_Do
);

    localparam int IW = $clog2(Tape_Num);
    localparam int CW = $clog2(Tape_Num + 1);
    localparam logic [CW-1:0] TC_LAST  = CW'(Tape_Num - 1);
    localparam logic [CW-1:0] MAC_LOAD = CW'(Tape_Num);
    localparam logic [IW-1:0] IDX_LAST = IW'(Tape_Num - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [31:0]              len_q;
    logic [31:0]              n_q;
    logic [IW-1:0]            wptr_q;
    logic [CW-1:0]            cnt_q;
    logic [pDATA_WIDTH-1:0]   acc_q;

    logic                     idle_like;
    logic                     start_run;
    logic                     ss_hs;
    logic                     last_smp;
    logic [CW-1:0]            mac_i;
    logic [CW-1:0]            clr_i;
    logic [IW-1:0]            mac_idx;
    logic [IW-1:0]            clr_idx;
    logic [IW-1:0]            rd_idx;
    logic [pDATA_WIDTH-1:0]   prod_lo;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [IW-1:0] idx);
        return pADDR_WIDTH'({idx, 2'b00});
    endfunction

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign start_run = idle_like && ap_start;
    assign cfg_gnt   = cfg_req && idle_like && !ap_start;
    assign ss_hs     = (state == S_WAIT_IN) && ss_tvalid;
    assign last_smp  = (n_q + 32'd1 == len_q);
    assign ap_idle   = idle_like;
    assign ap_done   = (state == S_DONE);
    assign cfg_rdata = cfg_rvalid ? tap_Do : '0;

    // MAC issues while cnt runs MAC_LOAD..1, CLEAR writes while cnt runs TC_LAST..0
    assign mac_i   = MAC_LOAD - cnt_q;
    assign clr_i   = TC_LAST - cnt_q;
    assign mac_idx = mac_i[IW-1:0];
    assign clr_idx = clr_i[IW-1:0];
    assign rd_idx  = (wptr_q >= mac_idx) ? (wptr_q - mac_idx)
                                         : (wptr_q + IW'(Tape_Num) - mac_idx);

    // low half of a two's-complement product is the same for signed or unsigned operands
    assign prod_lo = pDATA_WIDTH'($signed(tap_Do) * $signed(data_Do));

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state      <= S_IDLE;
            len_q      <= '0;
            n_q        <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            cfg_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cfg_rvalid <= cfg_gnt && !cfg_we;
            case (state)
                S_IDLE, S_DONE: begin
                    if (ap_start) begin
                        len_q  <= data_length;
                        n_q    <= '0;
                        wptr_q <= '0;
                        cnt_q  <= TC_LAST;
                    end
                end
                S_CLEAR: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_WAIT_IN: begin
                    if (ss_tvalid) begin
                        cnt_q <= MAC_LOAD;
                        acc_q <= '0;
                    end
                end
                S_MAC: begin
                    if (cnt_q != MAC_LOAD) acc_q <= acc_q + prod_lo;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_OUT: begin
                    if (sm_tready) begin
                        n_q    <= n_q + 32'd1;
                        wptr_q <= (wptr_q == IDX_LAST) ? '0 : wptr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        tap_WE    = 4'h0;
        tap_EN    = 1'b0;
        tap_Di    = '0;
        tap_A     = '0;
        data_WE   = 4'h0;
        data_EN   = 1'b0;
        data_Di   = '0;
        data_A    = '0;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        sm_tdata  = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (ap_start) begin
                    state_nxt = S_CLEAR;
                end else if (cfg_gnt) begin
                    tap_EN = 1'b1;
                    tap_A  = cfg_addr;
                    if (cfg_we) begin
                        tap_WE = 4'hF;
                        tap_Di = cfg_wdata;
                    end
                end
            end
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_addr(clr_idx);
                if (cnt_q == '0) state_nxt = (len_q == 32'd0) ? S_DONE : S_WAIT_IN;
            end
            S_WAIT_IN: begin
                ss_tready = ss_tvalid;
                if (ss_tvalid) begin
                    data_EN   = 1'b1;
                    data_WE   = 4'hF;
                    data_Di   = ss_tdata;
                    data_A    = word_addr(wptr_q);
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (cnt_q != '0) begin
                    tap_EN  = 1'b1;
                    tap_A   = word_addr(mac_idx);
                    data_EN = 1'b1;
                    data_A  = word_addr(rd_idx);
                end else begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                sm_tdata  = acc_q;
                sm_tlast  = last_smp;
                if (sm_tready) state_nxt = last_smp ? S_DONE : S_WAIT_IN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef FIR_TLAST_CHECK_EN
    logic err_q;

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            err_q <= 1'b0;
        end else if (start_run) begin
            err_q <= 1'b0;
        end else if (ss_hs && (ss_tlast != last_smp)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_tlast;
    logic unused_hs;
    assign unused_tlast = ss_tlast;
    assign unused_hs    = ss_hs ^ start_run;
    assign err          = 1'b0;
`endif

endmodule
